// File: rtl/prekey_generator.sv
// Serpent prekey/round-key generator.
// Produces w(i) words for external storage and S-boxes each 4-word group.
module prekey_generator (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [127:0] gen_preKeys,
    input  logic [127:0] pre_froundKeys,
    output logic         key_load,
    output logic [31:0]  pk_out,
    output logic [127:0] round_key,
    output logic         rk_valid,
    output logic [5:0]   rk_index,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        GEN,
        FLUSH
    } state_t;

    localparam logic [31:0] PHI = 32'h9E3779B9;
    localparam logic [7:0]  I_LAST = 8'd131;

    state_t       state;
    logic [7:0]   i;
    logic [5:0]   j;
    logic [31:0]  mix;
    logic [2:0]   sel;
    logic [127:0] rk_next;
    logic         grp_done;

    // S-box nibble n sits at bits [4n+3:4n] of each table constant
    function automatic logic [3:0] sbox(input logic [2:0] s, input logic [3:0] x);
        logic [63:0] t;
        unique case (s)
            3'd0: t = 64'hC90724DEB56A1F83;
            3'd1: t = 64'h43D68EB1A50972CF;
            3'd2: t = 64'h25B04E1DFAC39768;
            3'd3: t = 64'hE57A421D369C8BF0;
            3'd4: t = 64'hD7E9A4526B0C38F1;
            3'd5: t = 64'h176D8E30C9A4B25F;
            3'd6: t = 64'h0A3DF19EB6485C27;
            default: t = 64'h6539AC47B28E0FD1;
        endcase
        return t[{x, 2'b00} +: 4];
    endfunction

    // next prekey word, rotated left by 11, only driven while generating
    always_comb begin
        mix = gen_preKeys[127:96] ^ gen_preKeys[95:64]
            ^ gen_preKeys[63:32] ^ gen_preKeys[31:0]
            ^ PHI ^ {24'd0, i};
        pk_out = (state == GEN) ? {mix[20:0], mix[31:21]} : 32'd0;
    end

    // bitsliced S-box over the four newest stored words
    always_comb begin
        rk_next = '0;
        sel = 3'd3 - j[2:0];
        for (int b = 0; b < 32; b++) begin
            logic [3:0] o;
            o = sbox(sel, {pre_froundKeys[96+b], pre_froundKeys[64+b],
                           pre_froundKeys[32+b], pre_froundKeys[b]});
            rk_next[96+b] = o[3];
            rk_next[64+b] = o[2];
            rk_next[32+b] = o[1];
            rk_next[b]    = o[0];
        end
    end

    // a full group of four words sits in storage once i reaches 4j+4
    assign grp_done = (state == FLUSH)
                   || ((state == GEN) && (i >= 8'd4) && (i[1:0] == 2'b00));

    // control FSM with registered outputs and round-key capture
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            key_load  <= 1'b0;
            rk_valid  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            round_key <= '0;
            rk_index  <= '0;
        end else begin
            key_load <= 1'b0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
            if (grp_done) begin
                round_key <= rk_next;
                rk_index  <= j;
                rk_valid  <= 1'b1;
                j         <= j + 6'd1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        key_load <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= GEN;
                    i     <= '0;
                    j     <= '0;
                end
                GEN: begin
                    if (i == I_LAST) begin
                        state <= FLUSH;
                    end else begin
                        i <= i + 8'd1;
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prekey_generator.sv
// Scoreboard bench for prekey_generator with a prekey storage model.
// Expected round keys come from a direct Serpent key-schedule model.
module tb_prekey_generator;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic [127:0] gen_preKeys;
    logic [127:0] pre_froundKeys;
    logic         key_load;
    logic [31:0]  pk_out;
    logic [127:0] round_key;
    logic         rk_valid;
    logic [5:0]   rk_index;
    logic         busy;
    logic         done;

    prekey_generator dut (
        .clk(clk),
        .n_rst(n_rst),
        .start(start),
        .gen_preKeys(gen_preKeys),
        .pre_froundKeys(pre_froundKeys),
        .key_load(key_load),
        .pk_out(pk_out),
        .round_key(round_key),
        .rk_valid(rk_valid),
        .rk_index(rk_index),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // storage model: st[k] holds w(i-1-k)
    logic [255:0] key;
    bit           zm = 1'b0;
    logic [31:0]  st [8];

    always @(posedge clk) begin
        if (key_load) begin
            for (int k = 0; k < 8; k++) st[k] <= key[32*(7-k) +: 32];
        end else begin
            st[0] <= pk_out;
            for (int k = 1; k < 8; k++) st[k] <= st[k-1];
        end
    end

    assign gen_preKeys    = zm ? '0 : {st[7], st[4], st[2], st[0]};
    assign pre_froundKeys = zm ? '0 : {st[0], st[1], st[2], st[3]};

    typedef struct {
        int           idx;
        logic [127:0] k;
        bit           last;
    } exp_t;

    exp_t q [$];

    int SB [8][16] = '{
        '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
        '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
        '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
        '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
        '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
        '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
        '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
        '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
    };

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl11(input logic [31:0] x);
        return (x << 11) | (x >> 21);
    endfunction

    // Serpent key schedule: w[k] is w(k-8)
    task automatic push_expect(input logic [255:0] kk, input bit z);
        logic [31:0]  w [140];
        logic [31:0]  t;
        logic [127:0] rk;
        exp_t         e;
        int           s;
        int           x;
        for (int k = 0; k < 8; k++) w[k] = z ? 32'd0 : kk[32*k +: 32];
        for (int n = 0; n < 132; n++) begin
            t = w[n] ^ w[n+3] ^ w[n+5] ^ w[n+7] ^ 32'h9E3779B9 ^ n;
            w[n+8] = z ? 32'd0 : rotl11(t);
        end
        for (int g = 0; g < 33; g++) begin
            s = (((3 - g) % 8) + 8) % 8;
            rk = '0;
            for (int b = 0; b < 32; b++) begin
                x = w[8+4*g][b] + 2 * w[9+4*g][b]
                  + 4 * w[10+4*g][b] + 8 * w[11+4*g][b];
                for (int r = 0; r < 4; r++)
                    rk[32*r + b] = SB[s][x][r];
            end
            e.idx = g;
            e.k = rk;
            e.last = (g == 32);
            q.push_back(e);
        end
    endtask

    // monitor: pop expectation on each presented round key
    always @(negedge clk) begin
        if (n_rst && rk_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_rk_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rk_index", rk_index, e.idx);
                chk("round_key", round_key, e.k);
                chk("done_with_rk", done, e.last);
            end
        end else if (n_rst && done) begin
            chk("done_without_rk", done, 0);
        end
    end

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_key_load"}, key_load, 0);
        chk({nm, "_pk_out"}, pk_out, 0);
        chk({nm, "_rk_valid"}, rk_valid, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_round_key"}, round_key, 0);
        chk({nm, "_rk_index"}, rk_index, 0);
    endtask

    // one expansion from a start pulse, with ignored starts while busy
    task automatic run_one(input logic [255:0] kk, input bit z);
        int  nload = 0;
        int  nbusy = 0;
        bit  seen = 0;
        key = kk;
        zm = z;
        push_expect(kk, z);
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            if (key_load) nload++;
            if (busy) nbusy++;
            if (z && n == 1) chk("pk_out_i0", pk_out, 32'hBBCDCCF1);
            if (z && n == 2) chk("pk_out_i1", pk_out, 32'hBBCDC4F1);
            if (done) seen = 1;
            start = (n < 120) ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        chk("key_load_count", nload, 1);
        chk("busy_cycles", nbusy, 134);
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        logic [255:0] k2;
        int lc [2];
        int dc [2];
        int nl = 0;
        int nd = 0;
        key = '0;
        #1;
        chk_zero_outputs("reset");
        #12 n_rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_no_load", key_load | busy, 0);
        end

        run_one('0, 1'b1);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) k2[32*k +: 32] = $urandom;
            run_one(k2, 1'b0);
        end

        // abort mid-generation at i=50
        for (int k = 0; k < 8; k++) k2[32*k +: 32] = $urandom;
        key = k2;
        zm = 1'b0;
        push_expect(k2, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_key_load", key_load, 1);
        repeat (51) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk_zero_outputs("abort");
        q.delete();
        @(negedge clk);
        n_rst = 1'b1;
        repeat (150) @(negedge clk);
        chk("abort_stays_idle", busy, 0);
        run_one(k2, 1'b0);

        // start held high: back-to-back expansions
        for (int k = 0; k < 8; k++) k2[32*k +: 32] = $urandom;
        key = k2;
        push_expect(k2, 1'b0);
        push_expect(k2, 1'b0);
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < 400 && nd < 2; n++) begin
            @(negedge clk);
            if (key_load && nl < 2) lc[nl] = cyc;
            if (key_load) nl++;
            if (done) begin
                dc[nd] = cyc;
                nd++;
                if (nd == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b_done_count", nd, 2);
        chk("b2b_load_count", nl, 2);
        chk("b2b_load_gap", lc[1] - dc[0], 1);
        repeat (3) @(negedge clk);
        chk("b2b_queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
